// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: the NOP bubble, instruction size and the
// {instr, pc} record carried through the prefetch FIFO.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Show-ahead prefetch FIFO of fetch entries with synchronous clear and an occupancy count.
module fetch_prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  output fetch_entry_t             o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited sequential requests, buffers in-order
// responses and drops beats made stale by a redirect.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  en,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] LP_STEP = DATA_WIDTH'(INSTR_BYTES);

  logic [DATA_WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [DATA_WIDTH-1:0] r_rsp_pc, w_rsp_pc_next;
  logic [CW-1:0]         r_pending, w_pending_next;
  logic [CW-1:0]         r_drop_cnt, w_drop_next;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic          w_xfer, w_accept, w_pop, w_empty;
  fetch_entry_t  w_head, w_push_data;

  assign w_inflight     = {1'b0, r_pending} + {1'b0, w_count};
  assign imem_req_valid = rst_n && !redirect && (w_inflight < LP_DEPTH);
  assign imem_req_addr  = r_fetch_pc;
  assign w_xfer         = imem_req_valid && imem_req_ready;
  assign w_accept       = imem_rsp_valid && !redirect && (r_drop_cnt == '0);
  assign w_pop          = en && !w_empty && !redirect;
  assign w_push_data    = '{instr: imem_rsp_data, pc: r_rsp_pc};

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    w_rsp_pc_next   = r_rsp_pc;
    w_drop_next     = r_drop_cnt;
    w_pending_next  = r_pending + CW'(w_xfer) - CW'(imem_rsp_valid);
    if (redirect) begin
      w_fetch_pc_next = redirect_pc;
      w_rsp_pc_next   = redirect_pc;
      // Every outstanding beat is stale, including ones already marked for dropping.
      w_drop_next     = r_pending - CW'(imem_rsp_valid);
    end else begin
      if (w_xfer)   w_fetch_pc_next = r_fetch_pc + LP_STEP;
      if (w_accept) w_rsp_pc_next   = r_rsp_pc + LP_STEP;
      if (imem_rsp_valid && (r_drop_cnt != '0)) w_drop_next = r_drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_pending  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_rsp_pc   <= w_rsp_pc_next;
      r_pending  <= w_pending_next;
      r_drop_cnt <= w_drop_next;
    end
  end

  fetch_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (redirect),
    .i_push      (w_accept),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign valid_o   = !w_empty;
  assign Instr_o   = valid_o ? w_head.instr : NOP_INSTR;
  assign PC_o      = valid_o ? w_head.pc : '0;
  assign PCPlus4_o = valid_o ? (w_head.pc + LP_STEP) : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: latency-configurable memory model, PC scoreboard,
// table of streaming/redirect scenarios and hand-written corner sequences.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        valid_o;
  logic [31:0] Instr_o, PC_o, PCPlus4_o;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .en             (en),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .valid_o        (valid_o),
    .Instr_o        (Instr_o),
    .PC_o           (PC_o),
    .PCPlus4_o      (PCPlus4_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    int          lat;
    bit          rdy_toggle;
    bit          en_toggle;
    int          redir_at;
    logic [31:0] redir_pc;
    int          cycles;
    logic [31:0] exp_first_pc;
    int          exp_first_valid;
    int          exp_deliv;
  } vec_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch_pc;
  int          cyc, lat, n_checks, n_fail, n_deliv, n_xfer;
  logic        s_valid, s_rsp;
  logic [31:0] s_pc, s_pc4, s_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs and memory beat, sample mid-cycle, update model, advance.
  task automatic step(input logic en_v, input logic rd_v, input logic [31:0] rpc_v,
                      input logic rdy_v);
    logic [31:0] hp;
    en = en_v;
    redirect = rd_v;
    redirect_pc = rpc_v;
    imem_req_ready = rdy_v;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].addr ^ KEY;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #2;
    s_valid = valid_o;
    s_rsp   = imem_rsp_valid;
    s_pc    = PC_o;
    s_pc4   = PCPlus4_o;
    s_instr = Instr_o;
    if (valid_o) begin
      check("head_present", 32'(exp_q.size() > 0), 32'd1);
      hp = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
      check("head_pc", PC_o, hp);
      check("head_instr", Instr_o, hp ^ KEY);
      check("head_pc4", PCPlus4_o, hp + 32'd4);
      if (en && !redirect) begin
        n_deliv++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else begin
      check("idle_instr", Instr_o, NOP_INSTR);
      check("idle_pc", PC_o, 32'h0);
      check("idle_pc4", PCPlus4_o, 32'h0);
    end
    if (redirect) begin
      check("redir_no_req", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      exp_fetch_pc = redirect_pc;
    end else if (imem_req_valid) begin
      check("req_addr", imem_req_addr, exp_fetch_pc);
      if (imem_req_ready) begin
        n_xfer++;
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_q.push_back(exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; the memory model is reset alongside.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    en = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", Instr_o, NOP_INSTR);
    check("rst_pc", PC_o, 32'h0);
    check("rst_pc4", PCPlus4_o, 32'h0);
    mem_q.delete();
    exp_q.delete();
    exp_fetch_pc = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    n_deliv = 0;
    n_xfer = 0;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] pcs[$];
    int          first;
    logic [31:0] first_pc;

    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    lat = 1;

    //          lat rdyT  enT  redir  redir_pc       cyc first_pc       fv  deliv
    vecs[0] = '{1, 1'b0, 1'b0, -1, 32'h0000_0000, 12, 32'h0000_0000, 2, 10};
    vecs[1] = '{2, 1'b0, 1'b0, -1, 32'h0000_0000, 12, 32'h0000_0000, 3, 9};
    vecs[2] = '{3, 1'b0, 1'b0, 3,  32'h0000_0100, 16, 32'h0000_0100, 8, -1};
    vecs[3] = '{1, 1'b1, 1'b0, -1, 32'h0000_0000, 16, 32'h0000_0000, 2, 7};
    vecs[4] = '{1, 1'b0, 1'b1, 5,  32'h0000_0040, 16, 32'h0000_0040, 8, -1};
    vecs[5] = '{2, 1'b1, 1'b0, 4,  32'h0000_0200, 16, 32'h0000_0200, 9, -1};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      lat = vecs[v].lat;
      first = -1;
      first_pc = 32'hFFFF_FFFF;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step(vecs[v].en_toggle ? logic'(c % 2 == 0) : 1'b1,
             logic'(c == vecs[v].redir_at), vecs[v].redir_pc,
             vecs[v].rdy_toggle ? logic'(c % 2 == 0) : 1'b1);
        if (first < 0 && s_valid && c > vecs[v].redir_at) begin
          first = c;
          first_pc = s_pc;
        end
      end
      check($sformatf("v%0d_first_valid_cyc", v), 32'(first), 32'(vecs[v].exp_first_valid));
      check($sformatf("v%0d_first_pc", v), first_pc, vecs[v].exp_first_pc);
      if (vecs[v].exp_deliv >= 0)
        check($sformatf("v%0d_deliveries", v), 32'(n_deliv), 32'(vecs[v].exp_deliv));
    end

    // Stall: credits limit issue to DEPTH, head holds, then drains in order.
    do_reset();
    lat = 1;
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_xfers", 32'(n_xfer), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_head_valid", 32'(s_valid), 32'd1);
    check("stall_head_pc", s_pc, 32'h0);
    pcs.delete();
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_valid) pcs.push_back(s_pc);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_pc%0d", i), (pcs.size() > i) ? pcs[i] : 32'hFFFF_FFFF,
            32'(4 * i));

    // Response, pop request and redirect in the same cycle.
    do_reset();
    lat = 1;
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    check("simul_rsp_beat", 32'(s_rsp), 32'd1);
    check("simul_head_valid", 32'(s_valid), 32'd1);
    check("simul_empty_after", 32'(valid_o), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("simul_no_early_valid", 32'(s_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("simul_r3_valid", 32'(s_valid), 32'd1);
    check("simul_r3_pc", s_pc, 32'h0000_0300);

    // Address wrap-around at the top of the address space.
    do_reset();
    lat = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    pcs.delete();
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_valid && pcs.size() == 0) begin
        check("wrap_head_pc4", s_pc4, 32'h0);
        check("wrap_head_instr", s_instr, 32'hFFFF_FFFC ^ KEY);
      end
      if (s_valid) pcs.push_back(s_pc);
    end
    check("wrap_pc0", (pcs.size() > 0) ? pcs[0] : 32'h1, 32'hFFFF_FFFC);
    check("wrap_pc1", (pcs.size() > 1) ? pcs[1] : 32'h1, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
